// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl - multi-cycle MIPS control unit
//
// Sequences every instruction through FETCH / DECODE / EXEC / MEM / WB style
// states and drives the datapath enables and operand selects. Only the
// state is registered. All outputs are decoded combinationally from the
// state register and the IR opcode/funct fields.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (aborts current instruction)
//   op, funct  in   IR[31:26], IR[5:0]
//   zero       in   ALU Zero flag
//   mem_ready  in   memory access completes this cycle
//   PCWr/IRWr/MemRd/MemWr/RFWr  out  datapath enables
//   ALUOp      out  ALU operation code
//   ALUSrcA    out  00 PC, 01 rs, 10 shamt
//   ALUSrcB    out  00 rt, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
//   EXTOp      out  1 sign-extend, 0 zero-extend
//   RegDst     out  00 rt, 01 rd, 10 $31
//   WDSel      out  00 ALUOut, 01 MDR, 10 PC
//   NPCOp      out  00 PC+4, 01 branch target, 10 jump target, 11 rs
//   illegal    out  one-cycle pulse in DECODE for undecodable instructions
//   state      out  current state (debug)
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               IRWr,
    output logic               MemRd,
    output logic               MemWr,
    output logic               RFWr,
    output logic [3:0]         ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               EXTOp,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic [1:0]         NPCOp,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    // ALU operation codes shared with the ALU (ctrl_encode_def encoding)
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ALU_WB = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WB = 4'd6,
        ST_MEM_WR = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    // Instruction classes: everything after DECODE only needs to know which
    // group the instruction belongs to plus its ALU code / extension mode.
    typedef enum logic [3:0] {
        IC_RALU   = 4'd0,
        IC_RSHIFT = 4'd1,
        IC_IALU   = 4'd2,
        IC_LW     = 4'd3,
        IC_SW     = 4'd4,
        IC_BEQ    = 4'd5,
        IC_BNE    = 4'd6,
        IC_J      = 4'd7,
        IC_JAL    = 4'd8,
        IC_JR     = 4'd9,
        IC_ILL    = 4'd10
    } iclass_t;

    state_t     state_r;
    state_t     next_state_s;
    iclass_t    iclass_s;
    logic [3:0] alu_exec_s;
    logic       i_ext_s;

    assign state = STATE_W'(state_r);

    // Instruction decode: class, EXEC-stage ALU code and immediate extension
    always_comb begin
        iclass_s   = IC_ILL;
        alu_exec_s = ALU_NOP;
        i_ext_s    = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin iclass_s = IC_RALU;   alu_exec_s = ALU_ADD;  end
                    6'h22, 6'h23: begin iclass_s = IC_RALU;   alu_exec_s = ALU_SUB;  end
                    6'h24:        begin iclass_s = IC_RALU;   alu_exec_s = ALU_AND;  end
                    6'h25:        begin iclass_s = IC_RALU;   alu_exec_s = ALU_OR;   end
                    6'h27:        begin iclass_s = IC_RALU;   alu_exec_s = ALU_NOR;  end
                    6'h2a:        begin iclass_s = IC_RALU;   alu_exec_s = ALU_SLT;  end
                    6'h2b:        begin iclass_s = IC_RALU;   alu_exec_s = ALU_SLTU; end
                    6'h00:        begin iclass_s = IC_RSHIFT; alu_exec_s = ALU_SLL;  end
                    6'h02:        begin iclass_s = IC_RSHIFT; alu_exec_s = ALU_SRL;  end
                    6'h08:        begin iclass_s = IC_JR;                            end
                    default:      begin iclass_s = IC_ILL;                           end
                endcase
            end
            6'h08, 6'h09: begin iclass_s = IC_IALU; alu_exec_s = ALU_ADD; end
            6'h0c:        begin iclass_s = IC_IALU; alu_exec_s = ALU_AND; i_ext_s = 1'b0; end
            6'h0d:        begin iclass_s = IC_IALU; alu_exec_s = ALU_OR;  i_ext_s = 1'b0; end
            6'h0a:        begin iclass_s = IC_IALU; alu_exec_s = ALU_SLT; end
            6'h0f:        begin iclass_s = IC_IALU; alu_exec_s = ALU_LUI; i_ext_s = 1'b0; end
            6'h23:        begin iclass_s = IC_LW;  end
            6'h2b:        begin iclass_s = IC_SW;  end
            6'h04:        begin iclass_s = IC_BEQ; end
            6'h05:        begin iclass_s = IC_BNE; end
            6'h02:        begin iclass_s = IC_J;   end
            6'h03:        begin iclass_s = IC_JAL; end
            default:      begin iclass_s = IC_ILL; end
        endcase
    end

    // Next-state and output decode; reset forces every output to idle
    always_comb begin
        next_state_s = state_r;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        MemRd   = 1'b0;
        MemWr   = 1'b0;
        RFWr    = 1'b0;
        illegal = 1'b0;
        ALUOp   = ALU_NOP;
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        EXTOp   = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 2'b00;
        NPCOp   = 2'b00;
        if (rst) begin
            next_state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    MemRd   = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALU_ADD;
                    PCWr    = mem_ready;
                    IRWr    = mem_ready;
                    next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
                end
                ST_DECODE: begin
                    // Branch target is computed speculatively into ALUOut
                    ALUSrcB = 2'b11;
                    ALUOp   = ALU_ADD;
                    EXTOp   = 1'b1;
                    case (iclass_s)
                        IC_RALU, IC_RSHIFT, IC_IALU: next_state_s = ST_EXEC;
                        IC_LW, IC_SW:                next_state_s = ST_ADDR;
                        IC_BEQ, IC_BNE:              next_state_s = ST_BRANCH;
                        IC_J, IC_JAL, IC_JR:         next_state_s = ST_JUMP;
                        default: begin
                            illegal      = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC: begin
                    ALUOp = alu_exec_s;
                    next_state_s = ST_ALU_WB;
                    if (iclass_s == IC_IALU) begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                        EXTOp   = i_ext_s;
                    end else if (iclass_s == IC_RSHIFT) begin
                        ALUSrcA = 2'b10;
                    end else begin
                        ALUSrcA = 2'b01;
                    end
                end
                ST_ALU_WB: begin
                    RFWr   = 1'b1;
                    RegDst = (iclass_s == IC_IALU) ? 2'b00 : 2'b01;
                    next_state_s = ST_FETCH;
                end
                ST_ADDR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    EXTOp   = 1'b1;
                    ALUOp   = ALU_ADD;
                    next_state_s = (iclass_s == IC_SW) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    MemRd = 1'b1;
                    next_state_s = mem_ready ? ST_MEM_WB : ST_MEM_RD;
                end
                ST_MEM_WB: begin
                    RFWr  = 1'b1;
                    WDSel = 2'b01;
                    next_state_s = ST_FETCH;
                end
                ST_MEM_WR: begin
                    MemWr = 1'b1;
                    next_state_s = mem_ready ? ST_FETCH : ST_MEM_WR;
                end
                ST_BRANCH: begin
                    ALUSrcA = 2'b01;
                    ALUOp   = ALU_SUB;
                    NPCOp   = 2'b01;
                    PCWr    = (iclass_s == IC_BNE) ? ~zero : zero;
                    next_state_s = ST_FETCH;
                end
                ST_JUMP: begin
                    PCWr  = 1'b1;
                    NPCOp = (iclass_s == IC_JR) ? 2'b11 : 2'b10;
                    // jal links the already-incremented PC into $31
                    if (iclass_s == IC_JAL) begin
                        RFWr   = 1'b1;
                        RegDst = 2'b10;
                        WDSel  = 2'b10;
                    end else begin
                        RFWr   = 1'b0;
                    end
                    next_state_s = ST_FETCH;
                end
                default: begin
                    next_state_s = ST_FETCH;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl - scoreboard bench for mc_ctrl. The stimulus walks each
// instruction along its list of states (derived from its class), pushes the
// expected outputs of every cycle, and a monitor compares at the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                           A_OR  = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_NOR = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_LUI = 4'd10;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_E = 4'd2, S_W = 4'd3, S_A = 4'd4,
                           S_MR = 4'd5, S_MWB = 4'd6, S_MWR = 4'd7, S_B = 4'd8, S_J = 4'd9;

    localparam int C_RALU = 0, C_IALU = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                   C_BNE = 5, C_J = 6, C_JAL = 7, C_JR = 8, C_ILL = 9;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwr, irwr, memrd, memwr, rfwr, ill;
        logic [3:0] aluop;
        logic [1:0] srca, srcb;
        logic       extop;
        logic [1:0] regdst, wdsel, npcop;
    } obs_t;

    typedef struct {
        obs_t v;
        obs_t m;
        int   idx;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        logic [3:0] alu;
        logic       ext;
        logic [1:0] sa;
    } ins_t;

    logic clk, rst, zero, mem_ready;
    logic [5:0] op, funct;
    logic PCWr, IRWr, MemRd, MemWr, RFWr, EXTOp, illegal;
    logic [3:0] ALUOp, state;
    logic [1:0] ALUSrcA, ALUSrcB, RegDst, WDSel, NPCOp;

    exp_t exp_q[$];
    ins_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    mc_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd),
        .MemWr(MemWr), .RFWr(RFWr), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .RegDst(RegDst), .WDSel(WDSel),
        .NPCOp(NPCOp), .illegal(illegal), .state(state)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input int c,
                                input logic [3:0] a, input logic e, input logic [1:0] s);
        ins_t r;
        r.op = o; r.fn = f; r.cls = c; r.alu = a; r.ext = e; r.sa = s;
        return r;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be
    task automatic cyc(input bit r, input ins_t in, input bit z, input bit rdy,
                       input logic [3:0] st, input bit st_known);
        exp_t e;
        e.v = '0;
        e.m = '0;
        e.v.st = st;
        e.m.st = st_known ? 4'hF : 4'h0;
        e.m.pcwr = 1'b1; e.m.irwr = 1'b1; e.m.memrd = 1'b1;
        e.m.memwr = 1'b1; e.m.rfwr = 1'b1; e.m.ill = 1'b1;
        e.idx = cyc_no;
        rst = r; op = in.op; funct = in.fn; zero = z; mem_ready = rdy;
        if (r) begin
            e.m.aluop = 4'hF; e.m.srca = 2'b11; e.m.srcb = 2'b11; e.m.extop = 1'b1;
            e.m.regdst = 2'b11; e.m.wdsel = 2'b11; e.m.npcop = 2'b11;
        end else begin
            case (st)
                S_F: begin
                    e.v.memrd = 1'b1; e.v.srcb = 2'b01; e.v.aluop = A_ADD;
                    e.v.pcwr = rdy; e.v.irwr = rdy;
                    e.m.srca = 2'b11; e.m.srcb = 2'b11; e.m.aluop = 4'hF; e.m.npcop = 2'b11;
                end
                S_D: begin
                    e.v.srcb = 2'b11; e.v.aluop = A_ADD; e.v.ill = (in.cls == C_ILL);
                    e.m.srca = 2'b11; e.m.srcb = 2'b11; e.m.aluop = 4'hF;
                end
                S_E: begin
                    e.v.aluop = in.alu; e.m.aluop = 4'hF;
                    e.m.srca = 2'b11; e.m.srcb = 2'b11;
                    if (in.cls == C_IALU) begin
                        e.v.srca = 2'b01; e.v.srcb = 2'b10; e.v.extop = in.ext; e.m.extop = 1'b1;
                    end else begin
                        e.v.srca = in.sa; e.v.srcb = 2'b00;
                    end
                end
                S_W: begin
                    e.v.rfwr = 1'b1; e.v.wdsel = 2'b00;
                    e.v.regdst = (in.cls == C_RALU) ? 2'b01 : 2'b00;
                    e.m.wdsel = 2'b11; e.m.regdst = 2'b11;
                end
                S_A: begin
                    e.v.srca = 2'b01; e.v.srcb = 2'b10; e.v.extop = 1'b1; e.v.aluop = A_ADD;
                    e.m.srca = 2'b11; e.m.srcb = 2'b11; e.m.extop = 1'b1; e.m.aluop = 4'hF;
                end
                S_MR:  e.v.memrd = 1'b1;
                S_MWB: begin
                    e.v.rfwr = 1'b1; e.v.wdsel = 2'b01; e.v.regdst = 2'b00;
                    e.m.wdsel = 2'b11; e.m.regdst = 2'b11;
                end
                S_MWR: e.v.memwr = 1'b1;
                S_B: begin
                    e.v.srca = 2'b01; e.v.srcb = 2'b00; e.v.aluop = A_SUB; e.v.npcop = 2'b01;
                    e.v.pcwr = (in.cls == C_BEQ) ? z : !z;
                    e.m.srca = 2'b11; e.m.srcb = 2'b11; e.m.aluop = 4'hF; e.m.npcop = 2'b11;
                end
                S_J: begin
                    e.v.pcwr = 1'b1; e.v.npcop = (in.cls == C_JR) ? 2'b11 : 2'b10;
                    e.m.npcop = 2'b11;
                    if (in.cls == C_JAL) begin
                        e.v.rfwr = 1'b1; e.v.regdst = 2'b10; e.v.wdsel = 2'b10;
                        e.m.regdst = 2'b11; e.m.wdsel = 2'b11;
                    end
                end
                default: ;
            endcase
        end
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction; waits < 0 pick a random 0..2 stall per memory phase;
    // rst_cycle >= 0 asserts reset on that cycle of the instruction and abandons it.
    task automatic run_instr(input ins_t in, input int fwait, input int mwait,
                             input int rst_cycle, input bit z);
        logic [3:0] path[$];
        int idx, cnt, wleft;
        bit is_mem, rdy;
        path = '{S_F, S_D};
        case (in.cls)
            C_RALU, C_IALU:   begin path.push_back(S_E); path.push_back(S_W); end
            C_LW:             begin path.push_back(S_A); path.push_back(S_MR); path.push_back(S_MWB); end
            C_SW:             begin path.push_back(S_A); path.push_back(S_MWR); end
            C_BEQ, C_BNE:     path.push_back(S_B);
            C_J, C_JAL, C_JR: path.push_back(S_J);
            default: ;
        endcase
        idx = 0; cnt = 0;
        wleft = (fwait < 0) ? int'($urandom_range(0, 2)) : fwait;
        while (idx < path.size()) begin
            is_mem = (path[idx] == S_F) || (path[idx] == S_MR) || (path[idx] == S_MWR);
            rdy = is_mem ? (wleft == 0) : 1'($urandom_range(0, 1));
            if (cnt == rst_cycle) begin
                cyc(1'b1, in, z, rdy, path[idx], 1'b1);
                return;
            end
            cyc(1'b0, in, z, rdy, path[idx], 1'b1);
            cnt++;
            if (is_mem && wleft > 0) begin
                wleft--;
            end else begin
                idx++;
                wleft = (mwait < 0) ? int'($urandom_range(0, 2)) : mwait;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    always @(negedge clk) begin
        obs_t act;
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = '{st: state, pcwr: PCWr, irwr: IRWr, memrd: MemRd, memwr: MemWr,
                    rfwr: RFWr, ill: illegal, aluop: ALUOp, srca: ALUSrcA, srcb: ALUSrcB,
                    extop: EXTOp, regdst: RegDst, wdsel: WDSel, npcop: NPCOp};
            n_checks++;
            if (((act ^ e.v) & e.m) !== 25'd0)
                $display("FAIL outputs cycle %0d: actual %h required %h (mask %h)",
                         e.idx, act, e.v, e.m);
            else
                n_pass++;
            n_checks++;
            if (MemRd && MemWr)
                $display("FAIL rd_wr_exclusive cycle %0d: actual MemRd=%b MemWr=%b required not both",
                         e.idx, MemRd, MemWr);
            else
                n_pass++;
            n_checks++;
            if (RFWr && MemWr)
                $display("FAIL rf_memwr_exclusive cycle %0d: actual RFWr=%b MemWr=%b required not both",
                         e.idx, RFWr, MemWr);
            else
                n_pass++;
        end
    end

    initial begin
        ins_t in;
        int   guard;
        tbl.push_back(mk(6'h00, 6'h21, C_RALU, A_ADD,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h20, C_RALU, A_ADD,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h23, C_RALU, A_SUB,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h22, C_RALU, A_SUB,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h24, C_RALU, A_AND,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h25, C_RALU, A_OR,   1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h27, C_RALU, A_NOR,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h2a, C_RALU, A_SLT,  1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h2b, C_RALU, A_SLTU, 1'b0, 2'b01));
        tbl.push_back(mk(6'h00, 6'h00, C_RALU, A_SLL,  1'b0, 2'b10));
        tbl.push_back(mk(6'h00, 6'h02, C_RALU, A_SRL,  1'b0, 2'b10));
        tbl.push_back(mk(6'h00, 6'h08, C_JR,   A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h08, 6'h00, C_IALU, A_ADD,  1'b1, 2'b01));
        tbl.push_back(mk(6'h09, 6'h00, C_IALU, A_ADD,  1'b1, 2'b01));
        tbl.push_back(mk(6'h0c, 6'h00, C_IALU, A_AND,  1'b0, 2'b01));
        tbl.push_back(mk(6'h0d, 6'h00, C_IALU, A_OR,   1'b0, 2'b01));
        tbl.push_back(mk(6'h0a, 6'h00, C_IALU, A_SLT,  1'b1, 2'b01));
        tbl.push_back(mk(6'h0f, 6'h00, C_IALU, A_LUI,  1'b0, 2'b01));
        tbl.push_back(mk(6'h23, 6'h04, C_LW,   A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h2b, 6'h00, C_SW,   A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h04, 6'h00, C_BEQ,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h05, 6'h00, C_BNE,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h02, 6'h00, C_J,    A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h03, 6'h10, C_JAL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h3f, 6'h00, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h01, 6'h00, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h06, 6'h00, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h20, 6'h00, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h00, 6'h03, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h00, 6'h26, C_ILL,  A_NOP,  1'b0, 2'b00));
        tbl.push_back(mk(6'h00, 6'h18, C_ILL,  A_NOP,  1'b0, 2'b00));

        // Power-on reset: state unknown on the first cycle, FETCH afterwards
        cyc(1'b1, tbl[0], 1'b0, 1'b0, S_F, 1'b0);
        cyc(1'b1, tbl[0], 1'b0, 1'b1, S_F, 1'b1);

        // Directed cases
        run_instr(mk(6'h00, 6'h21, C_RALU, A_ADD, 1'b0, 2'b01), 0, 0, -1, 1'b0); // addu
        run_instr(mk(6'h23, 6'h04, C_LW,   A_NOP, 1'b0, 2'b00), 0, 2, -1, 1'b0); // lw, 2 waits
        run_instr(mk(6'h04, 6'h00, C_BEQ,  A_NOP, 1'b0, 2'b00), 0, 0, -1, 1'b1); // beq taken
        run_instr(mk(6'h05, 6'h00, C_BNE,  A_NOP, 1'b0, 2'b00), 0, 0, -1, 1'b1); // bne not taken
        run_instr(mk(6'h03, 6'h10, C_JAL,  A_NOP, 1'b0, 2'b00), 0, 0, -1, 1'b0); // jal
        run_instr(mk(6'h00, 6'h08, C_JR,   A_NOP, 1'b0, 2'b00), 0, 0, -1, 1'b0); // jr
        run_instr(mk(6'h3f, 6'h00, C_ILL,  A_NOP, 1'b0, 2'b00), 0, 0, -1, 1'b0); // illegal op
        run_instr(mk(6'h2b, 6'h00, C_SW,   A_NOP, 1'b0, 2'b00), 0, 3,  3, 1'b0); // sw reset in MEM_WR
        run_instr(mk(6'h00, 6'h25, C_RALU, A_OR,  1'b0, 2'b01), 0, 0, -1, 1'b0); // clean restart

        // Random instruction stream with random stalls, flags and resets
        for (int i = 0; i < 300; i++) begin
            in = tbl[$urandom_range(0, tbl.size() - 1)];
            if (in.op != 6'h00) in.fn = 6'($urandom);
            run_instr(in, -1, -1,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1,
                      1'($urandom_range(0, 1)));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: actual %0d entries left required 0", exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit: the issuing side of the ALU operation interface.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives ALUOp, operand selects, register-file/memory/PC/IR write enables.
- Consumes the opcode/funct fields of the instruction register and the ALU Zero flag; handshakes with a variable-latency memory via mem_ready.

Parameters:
- STATE_W, 4, width of the state register (exported on the debug port).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero flag (C == 0)
- mem_ready  in  1  memory access complete this cycle
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- MemRd  out  1  memory read request
- MemWr  out  1  memory write request
- RFWr  out  1  register-file write enable
- ALUOp  out  4  `ALU_* code from ctrl_encode_def.v
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt (zero-extended)
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
- EXTOp  out  1  1 sign-extend, 0 zero-extend
- RegDst  out  2  00 rt, 01 rd, 10 $31
- WDSel  out  2  00 ALUOut, 01 MDR, 10 PC
- NPCOp  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],00}, 11 rs
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  STATE_W  current state (debug)

Behaviour:
- Reset: rst sampled on the rising edge; next state = FETCH. While rst=1, all enables (PCWr, IRWr, MemRd, MemWr, RFWr) and illegal are forced 0; ALUOp=`ALU_NOP; all selects 0. Reset in any state, including a memory wait, aborts the instruction. No partial write follows.
- Outputs are combinational from the state register plus op/funct. Only the state is registered.
- Supported instructions:
  - R-type: addu, subu, add, sub, and, or, nor, slt, sltu, sll, srl, jr.
  - I-type and jumps: addi, addiu, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
- FETCH:
  - MemRd=1, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, NPCOp=00.
  - IRWr=PCWr=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - ALUSrcA=00, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
  - Next state: R-ALU/I-ALU → EXEC; lw/sw → ADDR; beq/bne → BRANCH; j/jal/jr → JUMP.
  - Unknown op or funct: illegal=1 for this cycle, next state FETCH. The instruction acts as a NOP; PC is already advanced.
- EXEC (R-type):
  - ALUSrcA=01, or 10 for sll/srl; ALUSrcB=00; ALUOp per funct.
  - Next state ALU_WB.
- EXEC (I-type):
  - ALUSrcA=01, ALUSrcB=10.
  - EXTOp=0 for andi/ori/lui, 1 otherwise.
  - ALUOp: ADD, ADD, AND, OR, SLT, LUI respectively.
- ALU_WB: RFWr=1, WDSel=00, RegDst=01 (R) or 00 (I). Next state FETCH.
- ADDR: ALUSrcA=01, ALUSrcB=10, EXTOp=1, ALUOp=ADD. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRd=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RFWr=1, WDSel=01, RegDst=00. Next state FETCH.
- MEM_WR: MemWr=1. Hold until mem_ready, then go to FETCH. MemWr stays asserted every wait cycle.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, NPCOp=01.
  - PCWr = zero (beq) or ~zero (bne).
  - Next state FETCH.
- JUMP:
  - PCWr=1, NPCOp=10 (j/jal) or 11 (jr).
  - jal additionally: RFWr=1, RegDst=10, WDSel=10 (PC already +4).
  - Next state FETCH.
- Cycle counts with mem_ready always 1: ALU 4, lw 5, sw 4, branch 3, jump 3. Each memory wait cycle adds 1.
- Encodings:
  - States: FETCH=0, DECODE=1, EXEC=2, ALU_WB=3, ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9.
  - Codes 10–15 are unreachable; if entered, next state is FETCH with all enables 0.
- At most one of MemRd/MemWr is asserted in any cycle. RFWr is never asserted in the same cycle as MemWr.

Test Plan:
- addu $3,$1,$2 (op=0, funct=0x21), mem_ready=1 → states 0,1,2,3,0. RFWr=1 only in ALU_WB with RegDst=01. ALUOp=`ALU_ADD in EXEC.
- lw 0x8C220004, mem_ready held 0 for 2 cycles in MEM_RD → states 0,1,4,5,5,5,6,0. MemRd high in all three MEM_RD cycles. RFWr=1, WDSel=01 in MEM_WB.
- beq with zero=1, then bne with zero=1 → PCWr=1, NPCOp=01 in BRANCH for beq; PCWr=0 for bne. Both return to FETCH after 3 cycles.
- jal 0x0C000010 → JUMP: PCWr=1, NPCOp=10, RFWr=1, RegDst=10, WDSel=10. jr (funct 0x08) → NPCOp=11, RFWr=0.
- op=0x3F → illegal=1 for exactly one cycle in DECODE, then FETCH. No RFWr/MemWr asserted at any point.
- sw in MEM_WR with mem_ready=0, rst=1 for one cycle → next state FETCH. MemWr=0 during the reset cycle, and no write occurs after reset deasserts.
